cpu6502_vector_sequencer: RTL and testbench

//  Owns the CPU bus during reset, NMI and IRQ entry. Runs the dummy-stack / push sequence, fetches the vector,

---
 rtl/cpu6502_vector_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_cpu6502_vector_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6502_vector_sequencer.sv
// Bus owner during reset, NMI and IRQ entry: dummy stack reads or pushes, vector fetch,
// then a one-cycle handback of the new PC and SP to the core.
module cpu6502_vector_sequencer #(
    parameter int unsigned ADDR_WIDTH         = 16,
    parameter logic [15:0] VECTOR_BASE        = 16'hFFFA,
    parameter logic [7:0]  STACK_PAGE         = 8'h01,
    parameter int unsigned RESET_DUMMY_CYCLES = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_nmi,
    input  logic                  i_irq,
    input  logic                  i_irq_mask,
    input  logic                  i_instr_boundary,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [7:0]            i_status,
    input  logic [7:0]            i_sp,
    input  logic [7:0]            i_data,
    output logic                  o_rw,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [7:0]            o_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [7:0]            o_sp,
    output logic                  o_set_i
);

    localparam int unsigned DCNT_W = 3;

    typedef enum logic [3:0] {
        ST_RESET_HOLD, ST_DUMMY, ST_IDLE, ST_PUSH_PCH, ST_PUSH_PCL,
        ST_PUSH_P, ST_VEC_LO, ST_VEC_HI, ST_DONE
    } state_t;

    typedef enum logic [1:0] {VSEL_NMI, VSEL_RST, VSEL_IRQ} vsel_t;

    state_t              state_q;
    vsel_t               vec_sel_q;
    logic                nmi_prev_q;
    logic                nmi_pending_q;
    logic [15:0]         pc_q;
    logic [7:0]          status_q;
    logic [DCNT_W-1:0]   dummy_cnt_q;

    logic                nmi_edge;
    logic                hijack;
    logic [7:0]          sp_dec;

    assign nmi_edge = i_nmi & ~nmi_prev_q;
    assign sp_dec   = o_sp - 8'd1;
    // Any NMI seen before the vector fetch of an IRQ steals that fetch.
    assign hijack   = (vec_sel_q == VSEL_IRQ) && (nmi_pending_q || nmi_edge);

    function automatic logic [ADDR_WIDTH-1:0] stack_addr(input logic [7:0] sp);
        return ADDR_WIDTH'({STACK_PAGE, sp});
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] vec_addr(input vsel_t sel);
        logic [15:0] v;
        case (sel)
            VSEL_NMI: v = VECTOR_BASE;
            VSEL_IRQ: v = VECTOR_BASE + 16'd4;
            default:  v = VECTOR_BASE + 16'd2;
        endcase
        return ADDR_WIDTH'(v);
    endfunction

    // Outputs are loaded on each transition with the values of the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_RESET_HOLD;
            vec_sel_q     <= VSEL_RST;
            nmi_prev_q    <= i_nmi;
            nmi_pending_q <= 1'b0;
            pc_q          <= '0;
            status_q      <= '0;
            dummy_cnt_q   <= '0;
            o_rw          <= 1'b1;
            o_address     <= '0;
            o_data        <= '0;
            o_busy        <= 1'b1;
            o_done        <= 1'b0;
            o_pc          <= '0;
            o_sp          <= '0;
            o_set_i       <= 1'b0;
        end else begin
            nmi_prev_q <= i_nmi;
            if (nmi_edge) nmi_pending_q <= 1'b1;
            o_done  <= 1'b0;
            o_set_i <= 1'b0;

            unique case (state_q)
                ST_RESET_HOLD: begin
                    vec_sel_q <= VSEL_RST;
                    o_busy    <= 1'b1;
                    o_rw      <= 1'b1;
                    o_data    <= '0;
                    if (RESET_DUMMY_CYCLES != 0) begin
                        state_q     <= ST_DUMMY;
                        dummy_cnt_q <= DCNT_W'(RESET_DUMMY_CYCLES - 1);
                        o_address   <= stack_addr(o_sp);
                    end else begin
                        state_q   <= ST_VEC_LO;
                        o_address <= vec_addr(VSEL_RST);
                    end
                end

                ST_DUMMY: begin
                    o_sp <= sp_dec;
                    if (dummy_cnt_q == '0) begin
                        state_q   <= ST_VEC_LO;
                        o_address <= vec_addr(VSEL_RST);
                    end else begin
                        dummy_cnt_q <= dummy_cnt_q - DCNT_W'(1);
                        o_address   <= stack_addr(sp_dec);
                    end
                end

                ST_IDLE: begin
                    if (i_instr_boundary && (nmi_pending_q || (i_irq && !i_irq_mask))) begin
                        state_q   <= ST_PUSH_PCH;
                        pc_q      <= i_pc[15:0];
                        status_q  <= (i_status | 8'h20) & ~8'h10;
                        o_sp      <= i_sp;
                        o_busy    <= 1'b1;
                        o_rw      <= 1'b0;
                        o_address <= stack_addr(i_sp);
                        o_data    <= i_pc[15:8];
                        if (nmi_pending_q) begin
                            vec_sel_q     <= VSEL_NMI;
                            nmi_pending_q <= nmi_edge;
                        end else begin
                            vec_sel_q <= VSEL_IRQ;
                        end
                    end else begin
                        o_busy    <= 1'b0;
                        o_rw      <= 1'b1;
                        o_address <= o_pc;
                        o_data    <= '0;
                    end
                end

                ST_PUSH_PCH, ST_PUSH_PCL: begin
                    if (hijack) begin
                        vec_sel_q     <= VSEL_NMI;
                        nmi_pending_q <= 1'b0;
                    end
                    o_sp      <= sp_dec;
                    o_address <= stack_addr(sp_dec);
                    if (state_q == ST_PUSH_PCH) begin
                        state_q <= ST_PUSH_PCL;
                        o_data  <= pc_q[7:0];
                    end else begin
                        state_q <= ST_PUSH_P;
                        o_data  <= status_q;
                    end
                end

                ST_PUSH_P: begin
                    state_q <= ST_VEC_LO;
                    o_sp    <= sp_dec;
                    o_rw    <= 1'b1;
                    o_data  <= '0;
                    if (hijack) begin
                        vec_sel_q     <= VSEL_NMI;
                        nmi_pending_q <= 1'b0;
                        o_address     <= vec_addr(VSEL_NMI);
                    end else begin
                        o_address <= vec_addr(vec_sel_q);
                    end
                end

                ST_VEC_LO: begin
                    state_q   <= ST_VEC_HI;
                    o_pc      <= ADDR_WIDTH'({8'h00, i_data});
                    o_address <= o_address + ADDR_WIDTH'(1);
                end

                ST_VEC_HI: begin
                    state_q   <= ST_DONE;
                    o_pc      <= ADDR_WIDTH'({i_data, o_pc[7:0]});
                    o_address <= ADDR_WIDTH'({i_data, o_pc[7:0]});
                    o_busy    <= 1'b0;
                    o_done    <= 1'b1;
                    o_set_i   <= 1'b1;
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_RESET_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6502_vector_sequencer.sv
// Directed bench for the vector sequencer: reset entry, IRQ/NMI entry, hijack, SP wrap, reset abort.
module tb_cpu6502_vector_sequencer;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_nmi = 1'b0;
    logic        i_irq = 1'b0;
    logic        i_irq_mask = 1'b0;
    logic        i_instr_boundary = 1'b0;
    logic [15:0] i_pc = '0;
    logic [7:0]  i_status = '0;
    logic [7:0]  i_sp = '0;
    logic [7:0]  i_data;
    logic        o_rw;
    logic [15:0] o_address;
    logic [7:0]  o_data;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_pc;
    logic [7:0]  o_sp;
    logic        o_set_i;

    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    cpu6502_vector_sequencer dut (
        .i_clk(clk), .i_reset(i_reset), .i_nmi(i_nmi), .i_irq(i_irq),
        .i_irq_mask(i_irq_mask), .i_instr_boundary(i_instr_boundary),
        .i_pc(i_pc), .i_status(i_status), .i_sp(i_sp), .i_data(i_data),
        .o_rw(o_rw), .o_address(o_address), .o_data(o_data), .o_busy(o_busy),
        .o_done(o_done), .o_pc(o_pc), .o_sp(o_sp), .o_set_i(o_set_i)
    );

    always #5 clk = ~clk;
    assign i_data = mem[o_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic rw, input logic [15:0] addr,
                           input logic [7:0] data);
        chk({tag, ".rw"}, 32'(o_rw), 32'(rw));
        chk({tag, ".addr"}, 32'(o_address), 32'(addr));
        if (!rw) chk({tag, ".data"}, 32'(o_data), 32'(data));
        chk({tag, ".busy"}, 32'(o_busy), 32'd1);
    endtask

    task automatic chk_done(input string tag, input logic [15:0] pc, input logic [7:0] sp);
        chk({tag, ".done"}, 32'(o_done), 32'd1);
        chk({tag, ".set_i"}, 32'(o_set_i), 32'd1);
        chk({tag, ".busy"}, 32'(o_busy), 32'd0);
        chk({tag, ".pc"}, 32'(o_pc), 32'(pc));
        chk({tag, ".sp"}, 32'(o_sp), 32'(sp));
        chk({tag, ".addr"}, 32'(o_address), 32'(pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int done_cnt;
        int wr_cnt;
        int busy_cnt;
        logic first_wr;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;

        // Reset hold values
        cyc(); cyc();
        chk("rst.busy", 32'(o_busy), 32'd1);
        chk("rst.rw", 32'(o_rw), 32'd1);
        chk("rst.addr", 32'(o_address), 32'd0);
        chk("rst.done", 32'(o_done), 32'd0);
        chk("rst.pc", 32'(o_pc), 32'd0);
        chk("rst.sp", 32'(o_sp), 32'd0);

        // Reset sequence
        i_reset = 1'b0;
        cyc(); chk_bus("rs.d0", 1'b1, 16'h0100, 8'h00);
        cyc(); chk_bus("rs.d1", 1'b1, 16'h01FF, 8'h00);
        cyc(); chk_bus("rs.d2", 1'b1, 16'h01FE, 8'h00);
        cyc(); chk_bus("rs.vlo", 1'b1, 16'hFFFC, 8'h00);
        cyc(); chk_bus("rs.vhi", 1'b1, 16'hFFFD, 8'h00);
        cyc(); chk_done("rs.done", 16'h1234, 8'hFD);
        cyc();
        chk("rs.idle_done", 32'(o_done), 32'd0);
        chk("rs.idle_addr", 32'(o_address), 32'h1234);

        // IRQ entry
        i_pc = 16'hABCD; i_status = 8'h81; i_sp = 8'hFD;
        i_irq = 1'b1; i_instr_boundary = 1'b1;
        cyc(); chk_bus("irq.pch", 1'b0, 16'h01FD, 8'hAB);
        i_irq = 1'b0; i_instr_boundary = 1'b0;
        cyc(); chk_bus("irq.pcl", 1'b0, 16'h01FC, 8'hCD);
        cyc(); chk_bus("irq.p", 1'b0, 16'h01FB, 8'hA1);
        cyc(); chk_bus("irq.vlo", 1'b1, 16'hFFFE, 8'h00);
        cyc(); chk_bus("irq.vhi", 1'b1, 16'hFFFF, 8'h00);
        cyc(); chk_done("irq.done", 16'h8000, 8'hFA);
        cyc();

        // IRQ blocked by mask, then by no boundary
        i_irq = 1'b1; i_irq_mask = 1'b1; i_instr_boundary = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (o_busy || !o_rw) busy_cnt++;
        end
        chk("mask.busy", 32'(busy_cnt), 32'd0);
        i_irq_mask = 1'b0; i_instr_boundary = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (o_busy || !o_rw) busy_cnt++;
        end
        chk("nobnd.busy", 32'(busy_cnt), 32'd0);
        i_irq = 1'b0;

        // NMI held high: a single sequence
        i_pc = 16'h1111; i_status = 8'h00; i_sp = 8'hFA;
        i_instr_boundary = 1'b1; i_nmi = 1'b1;
        done_cnt = 0; wr_cnt = 0; first_wr = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (!o_rw) begin
                wr_cnt++;
                if (first_wr) begin
                    chk("nmi.wr0_addr", 32'(o_address), 32'h01FA);
                    chk("nmi.wr0_data", 32'(o_data), 32'h11);
                    first_wr = 1'b0;
                end
            end
            if (o_done) begin
                done_cnt++;
                chk("nmi.pc", 32'(o_pc), 32'h9000);
                chk("nmi.sp", 32'(o_sp), 32'hF7);
            end
        end
        chk("nmi.done_cnt", 32'(done_cnt), 32'd1);
        chk("nmi.wr_cnt", 32'(wr_cnt), 32'd3);

        // NMI edge during IRQ PUSH_PCL hijacks the vector
        i_nmi = 1'b0; i_instr_boundary = 1'b0;
        cyc(); cyc();
        i_pc = 16'hABCD; i_status = 8'hB3; i_sp = 8'hFD;
        i_irq = 1'b1; i_instr_boundary = 1'b1;
        cyc(); chk_bus("hj.pch", 1'b0, 16'h01FD, 8'hAB);
        i_irq = 1'b0; i_instr_boundary = 1'b0;
        cyc(); chk_bus("hj.pcl", 1'b0, 16'h01FC, 8'hCD);
        i_nmi = 1'b1;
        cyc(); chk_bus("hj.p", 1'b0, 16'h01FB, 8'hA3);
        cyc(); chk_bus("hj.vlo", 1'b1, 16'hFFFA, 8'h00);
        cyc(); chk_bus("hj.vhi", 1'b1, 16'hFFFB, 8'h00);
        cyc(); chk_done("hj.done", 16'h9000, 8'hFA);
        i_instr_boundary = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (o_busy) busy_cnt++;
        end
        chk("hj.no_second", 32'(busy_cnt), 32'd0);

        // SP wrap
        i_pc = 16'h1234; i_status = 8'h00; i_sp = 8'h01; i_irq = 1'b1;
        cyc(); chk_bus("wr.pch", 1'b0, 16'h0101, 8'h12);
        i_irq = 1'b0;
        cyc(); chk_bus("wr.pcl", 1'b0, 16'h0100, 8'h34);
        cyc(); chk_bus("wr.p", 1'b0, 16'h01FF, 8'h20);
        cyc(); chk_bus("wr.vlo", 1'b1, 16'hFFFE, 8'h00);
        cyc(); chk_bus("wr.vhi", 1'b1, 16'hFFFF, 8'h00);
        cyc(); chk_done("wr.done", 16'h8000, 8'hFE);
        cyc();

        // Reset during PUSH_PCL aborts and restarts the reset sequence
        i_pc = 16'hABCD; i_sp = 8'hFD; i_irq = 1'b1;
        cyc(); chk_bus("ab.pch", 1'b0, 16'h01FD, 8'hAB);
        i_irq = 1'b0;
        cyc(); chk_bus("ab.pcl", 1'b0, 16'h01FC, 8'hCD);
        i_reset = 1'b1;
        cyc();
        chk("ab.rw", 32'(o_rw), 32'd1);
        chk("ab.busy", 32'(o_busy), 32'd1);
        chk("ab.addr", 32'(o_address), 32'd0);
        chk("ab.done", 32'(o_done), 32'd0);
        cyc();
        i_reset = 1'b0;
        done_cnt = 0; wr_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (k == 0) chk("ab.first_read", 32'(o_address), 32'h0100);
            if (!o_rw) wr_cnt++;
            if (o_done) begin
                done_cnt++;
                chk("ab.done_at", 32'(k), 32'd5);
                chk("ab.pc", 32'(o_pc), 32'h1234);
                chk("ab.sp", 32'(o_sp), 32'hFD);
            end
        end
        chk("ab.wr_cnt", 32'(wr_cnt), 32'd0);
        chk("ab.done_cnt", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
